sequencer_supervisor: RTL and testbench
=======================================

Name: sequencer_supervisor

Overview:
Supervisory controller in front of the rail sequencer. Arbitrates power-on requests from several sources (host command, front-panel button, management controller) into the single ENABLE of the sequencer. Enforces a minimum off time and a power-good timeout, and latches faults. Owns the sequencer retry/timeout configuration and updates it only while power is off.

Parameters:
NUM_REQ, 3, number of power-on requesters; index 0 is highest priority
MIN_OFF_CYC, 1000, minimum CLOCK cycles SEQ_ENABLE stays low after any deassertion
PG_TIMEOUT_CYC, 50000, cycles allowed from SEQ_ENABLE rise to PWRGD_ALL high
WDOG_CYC, 100000, watchdog period in cycles (SEQ_SUP_WDOG_EN only)

Ports:
CLOCK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
REQ_ON  in  NUM_REQ  level power-on requests, synchronous to CLOCK
REQ_KILL  in  1  emergency off (thermal); overrides all requests
NFAULT_IN  in  1  sequencer nFAULT, asynchronous; pulled-up Z reads as 1
PWRGD_ALL  in  1  AND of all rail power-goods, asynchronous
CFG_WR  in  1  one-cycle configuration write strobe
CFG_RETRIES  in  3  retry count to load
CFG_TIMEOUTDLY  in  3  restart-delay index to load
CFG_ACK  out  1  one-cycle pulse, one cycle after CFG_WR
CFG_ERR  out  1  valid with CFG_ACK; 1 = write rejected
SEQ_ENABLE  out  1  drives sequencer ENABLE
REG_RETRIES  out  3  drives sequencer REG_RETRIES
REG_TIMEOUTDLY  out  3  drives sequencer REG_TIMEOUTDLY
OWNER  out  $clog2(NUM_REQ) (min 1)  requester that caused the last power-up
STATE  out  3  current FSM state encoding
PWR_OK  out  1  high only in ON
FAULT_CNT  out  8  saturating count of FAULT_LOCK entries
WDOG_KICK  in  1  watchdog service pulse (SEQ_SUP_WDOG_EN only)

Behaviour:
- Reset: all outputs 0; STATE=OFF; shadow config 0. Reset mid-operation drops SEQ_ENABLE immediately (async). The sequencer then sequences down on its own.
- NFAULT_IN and PWRGD_ALL pass through 2-FF synchronizers. All references below use the synchronized versions. Base latency is 2 cycles.
- any_req = |REQ_ON & ~REQ_KILL.
- States and encodings:
  - OFF(0): SEQ_ENABLE=0. If any_req: latch OWNER = lowest set index, zero the counter, go to ON_WAIT.
  - ON_WAIT(1): SEQ_ENABLE=1; counter increments.
    - Exit priority: REQ_KILL, then fault, then !any_req, then PWRGD_ALL, then timeout.
    - REQ_KILL or !any_req → OFF_HOLD.
    - NFAULT low → FAULT_LOCK.
    - PWRGD_ALL high → ON.
    - Counter reaching PG_TIMEOUT_CYC-1 → FAULT_LOCK.
  - ON(2): SEQ_ENABLE=1, PWR_OK=1.
    - REQ_KILL or !any_req → OFF_HOLD.
    - NFAULT low → FAULT_LOCK.
    - PWRGD_ALL low for 2 consecutive synchronized samples → FAULT_LOCK.
  - OFF_HOLD(3): SEQ_ENABLE=0; counter from 0. After exactly MIN_OFF_CYC cycles → OFF. Requests during the hold are ignored, not queued.
  - FAULT_LOCK(4): SEQ_ENABLE=0; FAULT_CNT++ on entry, saturating at 255. Exit to OFF_HOLD only when REQ_ON==0 and NFAULT high. A requester must drop its request to clear a fault.
- Request sharing: power stays on while any requester asserts. OWNER is informational and does not change while powered.
- Simultaneous REQ_KILL and fault in ON: fault wins, so the fault is counted.
- Configuration:
  - CFG_WR is accepted only in OFF. On accept: REG_RETRIES/REG_TIMEOUTDLY update on the next edge; CFG_ACK=1, CFG_ERR=0.
  - In any other state: outputs unchanged; CFG_ACK=1, CFG_ERR=1.
  - CFG_WR in the same cycle as the OFF→ON_WAIT transition is accepted, because the state is sampled before the edge.
- Counter: one shared counter, width $clog2(max(MIN_OFF_CYC, PG_TIMEOUT_CYC, WDOG_CYC)+1). Cleared on every state change.

Optional Feature:
SEQ_SUP_WDOG_EN:
- Defined: in ON, a second counter clears on WDOG_KICK. Reaching WDOG_CYC without a kick → OFF_HOLD (power cycle) and FAULT_CNT++. Entering ON clears the counter.
- Undefined: WDOG_KICK is ignored, WDOG_CYC is unused, and no watchdog logic is synthesized.

Test Plan:
- REQ_ON=3'b110, PWRGD_ALL rises 100 cycles after SEQ_ENABLE → OWNER=1, STATE=ON, PWR_OK=1; drop both requests → SEQ_ENABLE=0, and it stays low exactly 1000 cycles even with REQ_ON reasserted.
- REQ_ON=3'b001, PWRGD_ALL held low → at 50000 cycles STATE=FAULT_LOCK, FAULT_CNT=1. Stays locked until REQ_ON=0, then OFF_HOLD → OFF.
- In ON, pulse NFAULT_IN low 1 cycle together with REQ_KILL → FAULT_LOCK, FAULT_CNT increments, SEQ_ENABLE low 3 cycles after the input.
- CFG_WR with 3'h7/3'h2 in OFF → CFG_ACK=1, CFG_ERR=0, REG_RETRIES=7, REG_TIMEOUTDLY=2. Same write in ON → CFG_ERR=1, registers unchanged.
- Assert RESET_N low while in ON → SEQ_ENABLE=0 in the same cycle, all outputs 0; after release STATE=OFF.
- SEQ_SUP_WDOG_EN, WDOG_CYC=1000: in ON with no kicks → OFF_HOLD at 1000 cycles, FAULT_CNT+1. With a kick every 500 cycles → stays ON.

Source files
------------

// File: rtl/sequencer_supervisor.sv
// Supervisory controller in front of the rail sequencer: arbitrates power-on requests into ENABLE,
// enforces minimum off time and power-good timeout, latches faults. Optional watchdog: SEQ_SUP_WDOG_EN.
module sequencer_supervisor #(
    parameter int  NUM_REQ        = 3,
    parameter int  MIN_OFF_CYC    = 1000,
    parameter int  PG_TIMEOUT_CYC = 50000,
    parameter int  WDOG_CYC       = 100000,
    localparam int OW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic [NUM_REQ-1:0] REQ_ON,
    input  logic               REQ_KILL,
    input  logic               NFAULT_IN,
    input  logic               PWRGD_ALL,
    input  logic               CFG_WR,
    input  logic [2:0]         CFG_RETRIES,
    input  logic [2:0]         CFG_TIMEOUTDLY,
    output logic               CFG_ACK,
    output logic               CFG_ERR,
    output logic               SEQ_ENABLE,
    output logic [2:0]         REG_RETRIES,
    output logic [2:0]         REG_TIMEOUTDLY,
    output logic [OW-1:0]      OWNER,
    output logic [2:0]         STATE,
    output logic               PWR_OK,
    output logic [7:0]         FAULT_CNT,
    input  logic               WDOG_KICK
);

    localparam int MAX_AB  = (MIN_OFF_CYC > PG_TIMEOUT_CYC) ? MIN_OFF_CYC : PG_TIMEOUT_CYC;
    localparam int MAX_CYC = (MAX_AB > WDOG_CYC) ? MAX_AB : WDOG_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_ON_WAIT    = 3'd1,
        ST_ON         = 3'd2,
        ST_OFF_HOLD   = 3'd3,
        ST_FAULT_LOCK = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic                seq_enable_q, seq_enable_d;
    logic                pwr_ok_q, pwr_ok_d;
    logic [7:0]          fault_cnt_q, fault_cnt_d;
    logic                cfg_ack_q, cfg_ack_d;
    logic                cfg_err_q, cfg_err_d;
    logic [2:0]          retries_q, retries_d;
    logic [2:0]          tdly_q, tdly_d;

    logic                nfault_meta_q, nfault_sync_q;
    logic                pg_meta_q, pg_sync_q, pg_prev_q;
    logic [NUM_REQ-1:0]  req_p1_q, req_p2_q;
    logic                kill_p1_q, kill_p2_q;

    logic                any_req_s;
    logic                fault_s;
    logic                pg_lost_s;
    logic                wdog_expire_s;
    logic                wdog_trip_s;
    logic                fault_inc_s;

    function automatic logic [OW-1:0] lowest_idx(input logic [NUM_REQ-1:0] req);
        logic [OW-1:0] idx;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = req[i] ? OW'(i) : idx;
        end
        return idx;
    endfunction

    // Async inputs get 2-FF synchronizers; sync requests/kill are delayed to stay aligned with them
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            nfault_meta_q <= 1'b1;
            nfault_sync_q <= 1'b1;
            pg_meta_q     <= 1'b0;
            pg_sync_q     <= 1'b0;
            pg_prev_q     <= 1'b0;
            req_p1_q      <= '0;
            req_p2_q      <= '0;
            kill_p1_q     <= 1'b0;
            kill_p2_q     <= 1'b0;
        end else begin
            nfault_meta_q <= NFAULT_IN;
            nfault_sync_q <= nfault_meta_q;
            pg_meta_q     <= PWRGD_ALL;
            pg_sync_q     <= pg_meta_q;
            pg_prev_q     <= pg_sync_q;
            req_p1_q      <= REQ_ON;
            req_p2_q      <= req_p1_q;
            kill_p1_q     <= REQ_KILL;
            kill_p2_q     <= kill_p1_q;
        end
    end

    assign any_req_s = (|req_p2_q) & ~kill_p2_q;
    assign fault_s   = ~nfault_sync_q;
    assign pg_lost_s = ~pg_sync_q & ~pg_prev_q;

`ifdef SEQ_SUP_WDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);
    logic [WW-1:0] wdog_q, wdog_d;

    assign wdog_expire_s = (state_q == ST_ON) && (wdog_q == WW'(WDOG_CYC - 1)) && !WDOG_KICK;

    // Watchdog counts only while ON; a kick or any other state clears it
    always_comb begin
        if ((state_q != ST_ON) || WDOG_KICK) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + WW'(1);
        end
    end

    // Watchdog counter register
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unused_wdog_kick_s;
    assign unused_wdog_kick_s = WDOG_KICK;
    assign wdog_expire_s      = 1'b0;
`endif

    // Next-state logic; in ON a fault outranks a kill so it is always counted
    always_comb begin
        state_d     = state_q;
        wdog_trip_s = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (any_req_s) state_d = ST_ON_WAIT;
                else           state_d = ST_OFF;
            end
            ST_ON_WAIT: begin
                if (kill_p2_q)                                state_d = ST_OFF_HOLD;
                else if (fault_s)                             state_d = ST_FAULT_LOCK;
                else if (!any_req_s)                          state_d = ST_OFF_HOLD;
                else if (pg_sync_q)                           state_d = ST_ON;
                else if (cnt_q == CW'(PG_TIMEOUT_CYC - 1))    state_d = ST_FAULT_LOCK;
                else                                          state_d = ST_ON_WAIT;
            end
            ST_ON: begin
                if (fault_s || pg_lost_s) begin
                    state_d = ST_FAULT_LOCK;
                end else if (!any_req_s) begin
                    state_d = ST_OFF_HOLD;
                end else if (wdog_expire_s) begin
                    state_d     = ST_OFF_HOLD;
                    wdog_trip_s = 1'b1;
                end else begin
                    state_d = ST_ON;
                end
            end
            ST_OFF_HOLD: begin
                if (cnt_q == CW'(MIN_OFF_CYC - 1)) state_d = ST_OFF;
                else                               state_d = ST_OFF_HOLD;
            end
            ST_FAULT_LOCK: begin
                if ((req_p2_q == '0) && !fault_s) state_d = ST_OFF_HOLD;
                else                              state_d = ST_FAULT_LOCK;
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Output/datapath next values; outputs are registered from the next state
    always_comb begin
        seq_enable_d = (state_d == ST_ON_WAIT) || (state_d == ST_ON);
        pwr_ok_d     = (state_d == ST_ON);

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == ST_ON_WAIT) || (state_q == ST_OFF_HOLD)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if ((state_q == ST_OFF) && (state_d == ST_ON_WAIT)) begin
            owner_d = lowest_idx(req_p2_q);
        end else begin
            owner_d = owner_q;
        end

        fault_inc_s = ((state_d == ST_FAULT_LOCK) && (state_q != ST_FAULT_LOCK)) || wdog_trip_s;
        if (fault_inc_s && (fault_cnt_q != 8'hFF)) begin
            fault_cnt_d = fault_cnt_q + 8'd1;
        end else begin
            fault_cnt_d = fault_cnt_q;
        end

        cfg_ack_d = CFG_WR;
        cfg_err_d = CFG_WR && (state_q != ST_OFF);
        if (CFG_WR && (state_q == ST_OFF)) begin
            retries_d = CFG_RETRIES;
            tdly_d    = CFG_TIMEOUTDLY;
        end else begin
            retries_d = retries_q;
            tdly_d    = tdly_q;
        end
    end

    // State and output registers
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_OFF;
            cnt_q        <= '0;
            owner_q      <= '0;
            seq_enable_q <= 1'b0;
            pwr_ok_q     <= 1'b0;
            fault_cnt_q  <= 8'd0;
            cfg_ack_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
            retries_q    <= 3'd0;
            tdly_q       <= 3'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            seq_enable_q <= seq_enable_d;
            pwr_ok_q     <= pwr_ok_d;
            fault_cnt_q  <= fault_cnt_d;
            cfg_ack_q    <= cfg_ack_d;
            cfg_err_q    <= cfg_err_d;
            retries_q    <= retries_d;
            tdly_q       <= tdly_d;
        end
    end

    assign STATE          = state_q;
    assign SEQ_ENABLE     = seq_enable_q;
    assign PWR_OK         = pwr_ok_q;
    assign OWNER          = owner_q;
    assign FAULT_CNT      = fault_cnt_q;
    assign CFG_ACK        = cfg_ack_q;
    assign CFG_ERR        = cfg_err_q;
    assign REG_RETRIES    = retries_q;
    assign REG_TIMEOUTDLY = tdly_q;

endmodule

// File: tb/tb_sequencer_supervisor.sv
// Directed bench for sequencer_supervisor: vector table for the power-up/down walk plus
// hand sequences for timeout, fault/kill collision, watchdog and asynchronous reset.
module tb_sequencer_supervisor;

    logic       clk;
    logic       rst_n;
    logic [2:0] req_on;
    logic       req_kill;
    logic       nfault;
    logic       pwrgd;
    logic       cfg_wr;
    logic [2:0] cfg_retries;
    logic [2:0] cfg_tdly;
    logic       wdog_kick;
    logic       cfg_ack;
    logic       cfg_err;
    logic       seq_en;
    logic [2:0] reg_retries;
    logic [2:0] reg_tdly;
    logic [1:0] owner;
    logic [2:0] state;
    logic       pwr_ok;
    logic [7:0] fault_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] S_OFF = 3'd0, S_WAIT = 3'd1, S_ON = 3'd2, S_HOLD = 3'd3, S_LOCK = 3'd4;

    sequencer_supervisor #(
        .NUM_REQ(3),
        .MIN_OFF_CYC(1000),
        .PG_TIMEOUT_CYC(50000),
        .WDOG_CYC(1000)
    ) dut (
        .CLOCK(clk),
        .RESET_N(rst_n),
        .REQ_ON(req_on),
        .REQ_KILL(req_kill),
        .NFAULT_IN(nfault),
        .PWRGD_ALL(pwrgd),
        .CFG_WR(cfg_wr),
        .CFG_RETRIES(cfg_retries),
        .CFG_TIMEOUTDLY(cfg_tdly),
        .CFG_ACK(cfg_ack),
        .CFG_ERR(cfg_err),
        .SEQ_ENABLE(seq_en),
        .REG_RETRIES(reg_retries),
        .REG_TIMEOUTDLY(reg_tdly),
        .OWNER(owner),
        .STATE(state),
        .PWR_OK(pwr_ok),
        .FAULT_CNT(fault_cnt),
        .WDOG_KICK(wdog_kick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;
        logic       pg;
        logic       wr;
        logic [2:0] ret;
        logic [2:0] tdly;
        int         cyc;
        logic [2:0] e_state;
        logic       e_seq;
        logic       e_pok;
        logic [1:0] e_owner;
        logic       e_ack;
        logic       e_err;
        logic [2:0] e_ret;
        logic [2:0] e_tdly;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic [2:0] req, input logic pg, input logic wr,
                                input logic [2:0] ret, input logic [2:0] tdly, input int cyc,
                                input logic [2:0] e_state, input logic e_seq, input logic e_pok,
                                input logic [1:0] e_owner, input logic e_ack, input logic e_err,
                                input logic [2:0] e_ret, input logic [2:0] e_tdly);
        vec_t v;
        v.req = req; v.pg = pg; v.wr = wr; v.ret = ret; v.tdly = tdly; v.cyc = cyc;
        v.e_state = e_state; v.e_seq = e_seq; v.e_pok = e_pok; v.e_owner = e_owner;
        v.e_ack = e_ack; v.e_err = e_err; v.e_ret = e_ret; v.e_tdly = e_tdly;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req_on = 3'b000; req_kill = 1'b0; nfault = 1'b1; pwrgd = 1'b0;
        cfg_wr = 1'b0; cfg_retries = 3'd0; cfg_tdly = 3'd0; wdog_kick = 1'b0;

        //          req     pg    wr    ret   tdly  cyc    state   seq   pok   own   ack   err   ret   tdly
        tbl[0]  = mk(3'b000, 1'b0, 1'b1, 3'd7, 3'd2, 1,   S_OFF,  1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 3'd7, 3'd2);
        tbl[1]  = mk(3'b000, 1'b0, 1'b0, 3'd0, 3'd0, 1,   S_OFF,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd7, 3'd2);
        tbl[2]  = mk(3'b110, 1'b0, 1'b0, 3'd0, 3'd0, 2,   S_OFF,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd7, 3'd2);
        tbl[3]  = mk(3'b110, 1'b0, 1'b0, 3'd0, 3'd0, 1,   S_WAIT, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 3'd7, 3'd2);
        tbl[4]  = mk(3'b110, 1'b0, 1'b0, 3'd0, 3'd0, 99,  S_WAIT, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 3'd7, 3'd2);
        tbl[5]  = mk(3'b110, 1'b1, 1'b0, 3'd0, 3'd0, 2,   S_WAIT, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 3'd7, 3'd2);
        tbl[6]  = mk(3'b110, 1'b1, 1'b0, 3'd0, 3'd0, 1,   S_ON,   1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 3'd7, 3'd2);
        tbl[7]  = mk(3'b110, 1'b1, 1'b1, 3'd3, 3'd4, 1,   S_ON,   1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 3'd7, 3'd2);
        tbl[8]  = mk(3'b110, 1'b1, 1'b0, 3'd0, 3'd0, 1,   S_ON,   1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 3'd7, 3'd2);
        tbl[9]  = mk(3'b100, 1'b1, 1'b0, 3'd0, 3'd0, 5,   S_ON,   1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 3'd7, 3'd2);
        tbl[10] = mk(3'b000, 1'b1, 1'b0, 3'd0, 3'd0, 2,   S_ON,   1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 3'd7, 3'd2);
        tbl[11] = mk(3'b000, 1'b1, 1'b0, 3'd0, 3'd0, 1,   S_HOLD, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 3'd7, 3'd2);
        tbl[12] = mk(3'b001, 1'b1, 1'b0, 3'd0, 3'd0, 999, S_HOLD, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 3'd7, 3'd2);
        tbl[13] = mk(3'b001, 1'b1, 1'b0, 3'd0, 3'd0, 1,   S_OFF,  1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 3'd7, 3'd2);
        tbl[14] = mk(3'b001, 1'b1, 1'b0, 3'd0, 3'd0, 1,   S_WAIT, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd7, 3'd2);
        tbl[15] = mk(3'b000, 1'b1, 1'b0, 3'd0, 3'd0, 3,   S_HOLD, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd7, 3'd2);

        step(3);
        rst_n = 1'b1;
        step(1);
        chk("rst_state", 32'(state), 32'(S_OFF));
        chk("rst_seq_en", 32'(seq_en), 32'd0);
        chk("rst_pwr_ok", 32'(pwr_ok), 32'd0);
        chk("rst_fault_cnt", 32'(fault_cnt), 32'd0);
        chk("rst_regs", 32'({reg_retries, reg_tdly}), 32'd0);

        for (int i = 0; i < 16; i++) begin
            req_on = tbl[i].req; pwrgd = tbl[i].pg; cfg_wr = tbl[i].wr;
            cfg_retries = tbl[i].ret; cfg_tdly = tbl[i].tdly;
            step(tbl[i].cyc);
            chk($sformatf("row%0d_state", i), 32'(state), 32'(tbl[i].e_state));
            chk($sformatf("row%0d_seq_en", i), 32'(seq_en), 32'(tbl[i].e_seq));
            chk($sformatf("row%0d_pwr_ok", i), 32'(pwr_ok), 32'(tbl[i].e_pok));
            chk($sformatf("row%0d_owner", i), 32'(owner), 32'(tbl[i].e_owner));
            chk($sformatf("row%0d_cfg_ack", i), 32'(cfg_ack), 32'(tbl[i].e_ack));
            chk($sformatf("row%0d_cfg_err", i), 32'(cfg_err), 32'(tbl[i].e_err));
            chk($sformatf("row%0d_retries", i), 32'(reg_retries), 32'(tbl[i].e_ret));
            chk($sformatf("row%0d_tdly", i), 32'(reg_tdly), 32'(tbl[i].e_tdly));
        end
        step(1000);
        chk("hold_done_state", 32'(state), 32'(S_OFF));

        // Power-good timeout: 50000 cycles in ON_WAIT, then locked until requests drop
        req_on = 3'b001; pwrgd = 1'b0;
        step(3);
        chk("pgto_wait", 32'(state), 32'(S_WAIT));
        step(49999);
        chk("pgto_last_wait", 32'(state), 32'(S_WAIT));
        step(1);
        chk("pgto_lock", 32'(state), 32'(S_LOCK));
        chk("pgto_seq_en", 32'(seq_en), 32'd0);
        chk("pgto_fault_cnt", 32'(fault_cnt), 32'd1);
        step(10);
        chk("pgto_still_lock", 32'(state), 32'(S_LOCK));
        req_on = 3'b000;
        step(2);
        chk("pgto_lock_pipe", 32'(state), 32'(S_LOCK));
        step(1);
        chk("pgto_unlock", 32'(state), 32'(S_HOLD));
        step(1000);
        chk("pgto_off", 32'(state), 32'(S_OFF));

        // Fault and kill on the same cycle while ON: fault wins and is counted
        req_on = 3'b001; pwrgd = 1'b1;
        step(4);
        chk("fk_on", 32'(state), 32'(S_ON));
        nfault = 1'b0; req_kill = 1'b1;
        step(1);
        chk("fk_seq_c1", 32'(seq_en), 32'd1);
        nfault = 1'b1; req_kill = 1'b0;
        step(1);
        chk("fk_seq_c2", 32'(seq_en), 32'd1);
        step(1);
        chk("fk_seq_c3", 32'(seq_en), 32'd0);
        chk("fk_state", 32'(state), 32'(S_LOCK));
        chk("fk_fault_cnt", 32'(fault_cnt), 32'd2);
        req_on = 3'b000;
        step(3);
        chk("fk_release", 32'(state), 32'(S_HOLD));
        step(1000);
        chk("fk_off", 32'(state), 32'(S_OFF));

`ifdef SEQ_SUP_WDOG_EN
        // Watchdog: no kicks trips at 1000 cycles; kicks every 500 keep power on
        req_on = 3'b001;
        step(4);
        chk("wd_on", 32'(state), 32'(S_ON));
        step(999);
        chk("wd_last_on", 32'(state), 32'(S_ON));
        step(1);
        chk("wd_trip", 32'(state), 32'(S_HOLD));
        chk("wd_fault_cnt", 32'(fault_cnt), 32'd3);
        step(1000);
        chk("wd_hold_off", 32'(state), 32'(S_OFF));
        step(2);
        chk("wd_on2", 32'(state), 32'(S_ON));
        for (int k = 0; k < 6; k++) begin
            step(499);
            wdog_kick = 1'b1;
            step(1);
            wdog_kick = 1'b0;
        end
        chk("wd_kicked_on", 32'(state), 32'(S_ON));
        chk("wd_kicked_cnt", 32'(fault_cnt), 32'd3);
`endif

        // Asynchronous reset while ON drops everything immediately
        req_on = 3'b001; pwrgd = 1'b1;
        for (int i = 0; i < 2500 && state != S_ON; i++) step(1);
        chk("ar_reach_on", 32'(state), 32'(S_ON));
        rst_n = 1'b0;
        #1;
        chk("ar_seq_en", 32'(seq_en), 32'd0);
        chk("ar_state", 32'(state), 32'(S_OFF));
        chk("ar_pwr_ok", 32'(pwr_ok), 32'd0);
        chk("ar_fault_cnt", 32'(fault_cnt), 32'd0);
        chk("ar_regs", 32'({reg_retries, reg_tdly, owner}), 32'd0);
        req_on = 3'b000;
        step(1);
        rst_n = 1'b1;
        step(2);
        chk("ar_after_state", 32'(state), 32'(S_OFF));
        chk("ar_after_seq", 32'(seq_en), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
